// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: controller states and default
// program-counter width / ISR entry address.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int          DEF_PC_W     = 10;
  localparam logic [9:0]  DEF_ISR_ADDR = 10'h200;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the input once and flags 0->1 transitions,
// so a level held high produces a single event.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= d;
    end
  end

  assign rise = d & ~irq_q;

endmodule

// File: rtl/int_controller.sv
// Single-source interrupt controller: latches one pending edge event, requests
// the CPU, captures the return address on acknowledge and tracks the ISR.
module int_controller
  import int_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] ISR_ADDR = PC_W'(DEF_ISR_ADDR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            irq,
  input  logic [7:0]      irq_data,
  input  logic            int_en,
  input  logic [PC_W-1:0] pc_in,
  input  logic            int_ack,
  input  logic            reti,
  output logic            int_req,
  output logic [PC_W-1:0] isr_addr,
  output logic [PC_W-1:0] ret_pc,
  output logic [7:0]      src_data,
  output logic            in_service,
  output logic            overrun
);

  state_t state;
  logic   pending;
  logic   rise;
  logic   accept;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (irq),
    .rise  (rise)
  );

  assign isr_addr = ISR_ADDR;
  assign accept   = (state == REQ) && int_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      ret_pc     <= '0;
      src_data   <= '0;
    end else begin
      // An edge landing on the acknowledge cycle becomes a fresh pending event.
      if (accept) begin
        ret_pc  <= pc_in;
        pending <= rise;
        overrun <= 1'b0;
        if (rise) begin
          src_data <= irq_data;
        end
      end else if (rise) begin
        if (!pending) begin
          pending  <= 1'b1;
          src_data <= irq_data;
        end else begin
          overrun <= 1'b1;
        end
      end

      // int_req follows REQ residency one cycle late, so it rises the cycle after entry.
      case (state)
        IDLE: begin
          int_req <= 1'b0;
          if (pending && int_en) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (!int_en) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            int_req <= 1'b1;
          end
        end
        SERVICE: begin
          int_req <= 1'b0;
          if (reti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: single event, masking, overrun, coincident
// edge on acknowledge, reset abort and stray control pulses.
module tb_int_controller;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       irq      = 1'b0;
  logic [7:0] irq_data = 8'h00;
  logic       int_en   = 1'b0;
  logic [9:0] pc_in    = 10'h000;
  logic       int_ack  = 1'b0;
  logic       reti     = 1'b0;

  logic       int_req;
  logic [9:0] isr_addr;
  logic [9:0] ret_pc;
  logic [7:0] src_data;
  logic       in_service;
  logic       overrun;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  int_controller #(
    .PC_W     (10),
    .ISR_ADDR (10'h200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .irq_data   (irq_data),
    .int_en     (int_en),
    .pc_in      (pc_in),
    .int_ack    (int_ack),
    .reti       (reti),
    .int_req    (int_req),
    .isr_addr   (isr_addr),
    .ret_pc     (ret_pc),
    .src_data   (src_data),
    .in_service (in_service),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int_req"},    {15'd0, int_req},    16'h0);
    check({tag, "_in_service"}, {15'd0, in_service}, 16'h0);
    check({tag, "_overrun"},    {15'd0, overrun},    16'h0);
    check({tag, "_ret_pc"},     {6'd0, ret_pc},      16'h0);
    check({tag, "_src_data"},   {8'd0, src_data},    16'h0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    check("isr_addr", {6'd0, isr_addr}, 16'h200);
    reset = 1'b1;
    tick();
    check("post_reset_req", {15'd0, int_req}, 16'h0);

    // Single event: pending, enter REQ, then int_req
    irq = 1'b1; irq_data = 8'h04; int_en = 1'b1;
    tick();
    check("single_lat0", {15'd0, int_req}, 16'h0);
    tick();
    check("single_lat1", {15'd0, int_req}, 16'h0);
    tick();
    check("single_lat2", {15'd0, int_req}, 16'h1);
    int_ack = 1'b1; pc_in = 10'h055;
    tick();
    int_ack = 1'b0;
    check("single_ret_pc",  {6'd0, ret_pc},      16'h055);
    check("single_src",     {8'd0, src_data},    16'h04);
    check("single_in_svc",  {15'd0, in_service}, 16'h1);
    check("single_req_low", {15'd0, int_req},    16'h0);
    tick();
    check("single_svc_req", {15'd0, int_req},    16'h0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("single_reti", {15'd0, in_service}, 16'h0);
    tick();
    tick();
    tick();
    check("level_no_retrigger", {15'd0, int_req}, 16'h0);
    irq = 1'b0;

    // Stray int_ack in IDLE
    int_ack = 1'b1; pc_in = 10'h3FF;
    tick();
    int_ack = 1'b0;
    check("stray_ack_svc", {15'd0, in_service}, 16'h0);
    check("stray_ack_pc",  {6'd0, ret_pc},      16'h055);
    tick();
    check("stray_ack_req", {15'd0, int_req},    16'h0);

    // Masked event held while int_en=0
    int_en = 1'b0; irq = 1'b1; irq_data = 8'h10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("masked_req", {15'd0, int_req}, 16'h0);
    end
    int_en = 1'b1;
    tick();
    check("unmask_lat1", {15'd0, int_req}, 16'h0);
    tick();
    check("unmask_lat2", {15'd0, int_req}, 16'h1);
    // Dropping int_en in REQ returns to IDLE with pending kept
    int_en = 1'b0;
    tick();
    check("req_drop_en", {15'd0, int_req}, 16'h0);
    int_en = 1'b1;
    tick();
    tick();
    check("req_reenter", {15'd0, int_req}, 16'h1);
    int_ack = 1'b1; pc_in = 10'h0AA;
    tick();
    int_ack = 1'b0;
    check("masked_ret_pc", {6'd0, ret_pc},   16'h0AA);
    check("masked_src",    {8'd0, src_data}, 16'h10);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    irq = 1'b0;
    tick();

    // Overrun: second rise before acknowledge
    irq = 1'b1; irq_data = 8'h01;
    tick();
    irq = 1'b0;
    tick();
    irq = 1'b1; irq_data = 8'h02;
    tick();
    irq = 1'b0;
    check("ovr_flag", {15'd0, overrun},  16'h1);
    check("ovr_src",  {8'd0, src_data},  16'h01);
    check("ovr_req",  {15'd0, int_req},  16'h1);
    // Stray reti while in REQ
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("stray_reti_req", {15'd0, int_req},    16'h1);
    check("stray_reti_svc", {15'd0, in_service}, 16'h0);
    int_ack = 1'b1; pc_in = 10'h111;
    tick();
    int_ack = 1'b0;
    check("ovr_cleared", {15'd0, overrun},    16'h0);
    check("ovr_ack_svc", {15'd0, in_service}, 16'h1);
    check("ovr_ack_src", {8'd0, src_data},    16'h01);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    tick();
    check("ovr_no_repend", {15'd0, int_req}, 16'h0);

    // Coincident rise on the acknowledge cycle
    irq = 1'b1; irq_data = 8'h20;
    tick();
    irq = 1'b0;
    tick();
    tick();
    check("coin_req", {15'd0, int_req}, 16'h1);
    irq = 1'b1; irq_data = 8'h08; int_ack = 1'b1; pc_in = 10'h123;
    tick();
    int_ack = 1'b0;
    check("coin_src",     {8'd0, src_data},    16'h08);
    check("coin_ret_pc",  {6'd0, ret_pc},      16'h123);
    check("coin_in_svc",  {15'd0, in_service}, 16'h1);
    check("coin_overrun", {15'd0, overrun},    16'h0);
    tick();
    check("coin_svc_req", {15'd0, int_req}, 16'h0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("coin_reti", {15'd0, in_service}, 16'h0);
    tick();
    check("coin_rereq_lat1", {15'd0, int_req}, 16'h0);
    tick();
    check("coin_rereq", {15'd0, int_req}, 16'h1);

    // Abort during SERVICE, irq held high across reset release
    int_ack = 1'b1; pc_in = 10'h077;
    tick();
    int_ack = 1'b0;
    check("abort_pre_svc", {15'd0, in_service}, 16'h1);
    irq_data = 8'h40;
    reset = 1'b0;
    #1;
    check_all_zero("abort_async");
    tick();
    check_all_zero("abort_held");
    reset = 1'b1;
    tick();
    check("abort_event_src", {8'd0, src_data}, 16'h40);
    check("abort_event_req", {15'd0, int_req}, 16'h0);
    tick();
    tick();
    check("abort_event_req2", {15'd0, int_req}, 16'h1);
    int_ack = 1'b1; pc_in = 10'h2A5;
    tick();
    int_ack = 1'b0;
    check("abort_ack_pc", {6'd0, ret_pc}, 16'h2A5);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    tick();
    tick();
    check("abort_one_event", {15'd0, int_req}, 16'h0);
    check("abort_final_svc", {15'd0, in_service}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
